alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the decoder's outputs (4-bit ALUOp, carry, PVS write enable) plus two 16-bit operands, and produces a registered result and P/V/S status flags.
- Sits after the control unit, on the consuming end of the ALUOp/carry interface.
- Valid/ready handshake on both input and output.
- Shifts run serially, one bit per cycle; all other ops complete in one cycle.

---
 rtl/alu_exec_unit_pkg.sv | 32 +++
 rtl/alu_flag_gen.sv | 47 ++++
 rtl/alu_exec_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU: ALUOp codes, widths, flag bit
// positions and FSM state encodings.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_exec_unit_pkg;

    localparam int ALU_DATA_W  = 16;
    localparam int ALU_SHAMT_W = 4;

    // ALUOp codes as produced by the control unit
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_OR  = 4'b1110;
    localparam logic [3:0] OP_NOT = 4'b1100;
    localparam logic [3:0] OP_ALS = 4'b0101;
    localparam logic [3:0] OP_ARS = 4'b0100;

    // Bit positions inside the {P,V,S} flag register
    localparam int FLAG_P = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_ALS) || (op == OP_ARS);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Purpose: combinational {P,V,S} flag computation for one ALU result.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: op (ALUOp), a (operand A / original shift source), b_msb (sign of B),
//        shamt (shift amount), res (final result), flags ({P,V,S}).
module alu_flag_gen
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic [3:0]         op,
    input  logic [DATA_W-1:0]  a,
    input  logic               b_msb,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  res,
    output logic [2:0]         flags
);

    logic sign;
    logic ovf;

    always_comb begin
        sign = res[DATA_W-1];
        ovf  = 1'b0;
        case (op)
            OP_ADD: ovf = (a[DATA_W-1] == b_msb) && (sign != a[DATA_W-1]);
            OP_SUB: ovf = (a[DATA_W-1] != b_msb) && (sign != a[DATA_W-1]);
            OP_ALS: begin
                // The top shamt bits of A are the ones pushed out; any of them
                // disagreeing with the final sign means the value changed sign
                // or magnitude class, i.e. an arithmetic overflow.
                for (int i = 0; i < DATA_W; i++) begin
                    if ((i + int'(shamt) >= DATA_W) && (a[i] != sign)) begin
                        ovf = 1'b1;
                    end
                end
            end
            default: ovf = 1'b0;
        endcase

        flags         = 3'b000;
        flags[FLAG_S] = sign;
        flags[FLAG_V] = ovf;
        flags[FLAG_P] = (res != '0) && !sign;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose: execute-stage ALU with registered result and {P,V,S} flag register.
// Latency: 1 cycle; ALS/ARS with N>0 take 1+N cycles (serial), or 1 cycle when
//          ALU_FAST_SHIFT_EN is defined (barrel shifter, busy tied low).
// Backpressure: result held until out_ready; in_ready drops while shifting or
//               while an untaken result is pending.
// Ports: clk/reset (sync, active-high); in_valid/in_ready, alu_op, carry_in,
//        pvs_we, src_a, src_b on the input side; out_valid/out_ready, result,
//        pvs on the output side; busy is high while a serial shift runs.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic              carry_in,
    input  logic              pvs_we,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        pvs,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [2:0]          pvs_q, pvs_d;
    // Serial-shift context: working value, remaining count, and the original
    // operand/amount kept for the ALS overflow check at completion.
    logic [DATA_W-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [3:0]          op_q, op_d;
    logic                we_q, we_d;

    logic                accept;
    logic [SHAMT_W-1:0]  shamt_in;
    logic [DATA_W-1:0]   cin_ext;
    logic [DATA_W-1:0]   calc;
    logic [DATA_W-1:0]   step;

    logic [3:0]          fg_op;
    logic [DATA_W-1:0]   fg_a;
    logic                fg_b_msb;
    logic [SHAMT_W-1:0]  fg_shamt;
    logic [DATA_W-1:0]   fg_res;
    logic [2:0]          flags;

    assign shamt_in = src_b[SHAMT_W-1:0];
    assign cin_ext  = {{(DATA_W-1){1'b0}}, carry_in};
    assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle result for the op presented at the input
    always_comb begin
        calc = '0;
        case (alu_op)
            OP_ADD: calc = src_a + src_b + cin_ext;
            OP_SUB: calc = src_a - src_b + cin_ext;
            OP_AND: calc = (src_a & src_b) + cin_ext;
            OP_OR:  calc = (src_a | src_b) + cin_ext;
            OP_NOT: calc = ~src_a + cin_ext;
`ifdef ALU_FAST_SHIFT_EN
            OP_ALS: calc = src_a << shamt_in;
            OP_ARS: calc = $unsigned($signed(src_a) >>> shamt_in);
`else
            // Only reached with N=0; nonzero amounts go through SHIFT.
            OP_ALS: calc = src_a;
            OP_ARS: calc = src_a;
`endif
            default: calc = '0;
        endcase
    end

    // One-bit step of the in-flight serial shift
    assign step = (op_q == OP_ALS) ? {work_q[DATA_W-2:0], 1'b0}
                                   : {work_q[DATA_W-1], work_q[DATA_W-1:1]};

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        pvs_d       = pvs_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        shamt_d     = shamt_q;
        a_d         = a_q;
        op_d        = op_q;
        we_d        = we_q;

        fg_op       = alu_op;
        fg_a        = src_a;
        fg_b_msb    = src_b[DATA_W-1];
        fg_shamt    = shamt_in;
        fg_res      = calc;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift_op(alu_op) && (shamt_in != '0)) begin
                        state_d = ST_SHIFT;
                        cnt_d   = shamt_in;
                        work_d  = src_a;
                        shamt_d = shamt_in;
                        a_d     = src_a;
                        op_d    = alu_op;
                        we_d    = pvs_we;
                    end else
`endif
                    begin
                        result_d    = calc;
                        out_valid_d = 1'b1;
                        if (pvs_we) begin
                            pvs_d = flags;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                // Flags are judged against the original operand, not the
                // partially shifted working value.
                fg_op    = op_q;
                fg_a     = a_q;
                fg_b_msb = 1'b0;
                fg_shamt = shamt_q;
                fg_res   = step;
                work_d   = step;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d    = step;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                    if (we_q) begin
                        pvs_d = flags;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu_flag_gen #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_flag_gen (
        .op    (fg_op),
        .a     (fg_a),
        .b_msb (fg_b_msb),
        .shamt (fg_shamt),
        .res   (fg_res),
        .flags (flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            pvs_q       <= 3'b000;
            work_q      <= '0;
            cnt_q       <= '0;
            shamt_q     <= '0;
            a_q         <= '0;
            op_q        <= OP_ADD;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            pvs_q       <= pvs_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            shamt_q     <= shamt_d;
            a_q         <= a_d;
            op_q        <= op_d;
            we_q        <= we_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign pvs       = pvs_q;
`ifdef ALU_FAST_SHIFT_EN
    assign busy      = 1'b0;
`else
    assign busy      = (state_q == ST_SHIFT);
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected result/flags/latency are pushed
// when an op is accepted and compared when the result is handed off.
// Honours ALU_FAST_SHIFT_EN for the expected shift latency.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        carry_in;
    logic        pvs_we;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  pvs;
    logic        busy;

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .carry_in  (carry_in),
        .pvs_we    (pvs_we),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .pvs       (pvs),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  pvs;
        int          lat;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         cyc    = 0;
    int         busy_cnt = 0;
    logic [2:0] model_pvs = 3'b000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model written straight from the op table
    task automatic model(input logic [3:0] op, input logic cin, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] r, output logic v,
                         output int lat);
        int n;
        n   = int'(b[3:0]);
        r   = 16'h0000;
        v   = 1'b0;
        lat = 1;
        case (op)
            4'b0000: begin
                r = a + b + {15'b0, cin};
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'b0001: begin
                r = a - b + {15'b0, cin};
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'b1101: r = (a & b) + {15'b0, cin};
            4'b1110: r = (a | b) + {15'b0, cin};
            4'b1100: r = ~a + {15'b0, cin};
            4'b0101: begin
                r = a;
                for (int k = 0; k < n; k++) r = {r[14:0], 1'b0};
                for (int k = 0; k < n; k++) if (a[15-k] != r[15]) v = 1'b1;
                lat = 1 + n;
            end
            4'b0100: begin
                r = a;
                for (int k = 0; k < n; k++) r = {r[15], r[15:1]};
                lat = 1 + n;
            end
            default: r = 16'h0000;
        endcase
`ifdef ALU_FAST_SHIFT_EN
        lat = 1;
`endif
    endtask

    // Call at a drive point (just after a posedge). Returns just after the
    // accepting posedge; waits = cycles spent waiting for in_ready.
    task automatic send(input logic [3:0] op, input logic cin, input logic we,
                        input logic [15:0] a, input logic [15:0] b, output int waits);
        exp_t        e;
        logic [15:0] r;
        logic        v;
        int          lat;
        int          t;
        alu_op   = op;
        carry_in = cin;
        pvs_we   = we;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        waits = t;
        if (t == 200) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            model(op, cin, a, b, r, v, lat);
            if (we) model_pvs = {(r != 16'h0000) && !r[15], v, r[15]};
            e.res = r;
            e.pvs = model_pvs;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 300; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy) busy_cnt++;

    // Output monitor
    logic prev_vld   = 1'b0;
    logic prev_taken = 1'b0;
    int   cur_lat    = 0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && (!prev_vld || prev_taken)) begin
            if (sb.size() == 0) check("unexpected_output", 32'd1, 32'd0);
            else cur_lat = cyc - sb[0].acc;
        end
        if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("pvs", pvs, e.pvs);
            check("latency", cur_lat, e.lat);
        end
        prev_vld   = out_valid;
        prev_taken = out_valid && out_ready;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    localparam logic [3:0] OPS [8] = '{4'b0000, 4'b0001, 4'b1101, 4'b1110,
                                      4'b1100, 4'b0101, 4'b0100, 4'b0111};

    initial begin
        int w;
        int exp_busy;
        reset     = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 4'b0000;
        carry_in  = 1'b0;
        pvs_we    = 1'b0;
        src_a     = 16'h0000;
        src_b     = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_pvs", pvs, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready_after", in_ready, 1'b1);

        // ADD overflow, then TCP via NOT without flag update
        send(4'b0000, 1'b0, 1'b1, 16'h7FFF, 16'h0001, w);
        send(4'b1100, 1'b1, 1'b0, 16'h0005, 16'h0000, w);
        drain();

        // Serial ALS: busy for N cycles
        busy_cnt = 0;
        send(4'b0101, 1'b0, 1'b1, 16'h0003, 16'h0004, w);
        drain();
`ifdef ALU_FAST_SHIFT_EN
        exp_busy = 0;
`else
        exp_busy = 4;
`endif
        check("als_busy_cycles", busy_cnt, exp_busy);
        send(4'b0101, 1'b0, 1'b1, 16'h4000, 16'h0001, w);
        send(4'b0100, 1'b0, 1'b1, 16'h8000, 16'h000F, w);
        send(4'b0100, 1'b1, 1'b1, 16'h1234, 16'h0000, w);
        drain();

        // Mixed ops with random operands, including an undefined code
        for (int i = 0; i < 16; i++) begin
            send(OPS[i % 8], 1'($urandom_range(1)), 1'($urandom_range(1)),
                 16'($urandom), 16'($urandom), w);
        end
        drain();

        // Backpressure: result held, in_ready low, then no-bubble handover
        out_ready = 1'b0;
        send(4'b0001, 1'b0, 1'b1, 16'h0005, 16'h0007, w);
        for (int i = 0; i < 3; i++) begin
            check("bp_result", result, 16'hFFFE);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(4'b0000, 1'b0, 1'b1, 16'h0001, 16'h0002, w);
        check("bp_same_cycle_accept", w, 0);
        drain();

        // Reset during the third cycle of an 8-bit shift
        send(4'b0101, 1'b0, 1'b1, 16'h0101, 16'h0008, w);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        model_pvs = 3'b000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pvs", pvs, 3'b000);
        send(4'b0000, 1'b0, 1'b1, 16'h1000, 16'h0234, w);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
